// File: rtl/cond_pkg.sv
// Shared encodings for the condition/flag stage: condition codes, NZCV bit
// positions and FlagW bit positions.
package cond_pkg;

   localparam logic [3:0] COND_EQ = 4'h0;
   localparam logic [3:0] COND_NE = 4'h1;
   localparam logic [3:0] COND_CS = 4'h2;
   localparam logic [3:0] COND_CC = 4'h3;
   localparam logic [3:0] COND_MI = 4'h4;
   localparam logic [3:0] COND_PL = 4'h5;
   localparam logic [3:0] COND_VS = 4'h6;
   localparam logic [3:0] COND_VC = 4'h7;
   localparam logic [3:0] COND_HI = 4'h8;
   localparam logic [3:0] COND_LS = 4'h9;
   localparam logic [3:0] COND_GE = 4'hA;
   localparam logic [3:0] COND_LT = 4'hB;
   localparam logic [3:0] COND_GT = 4'hC;
   localparam logic [3:0] COND_LE = 4'hD;
   localparam logic [3:0] COND_AL = 4'hE;
   localparam logic [3:0] COND_NV = 4'hF;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   localparam int FLAGW_NZ = 1;
   localparam int FLAGW_CV = 0;

endpackage

// File: rtl/cond_eval.sv
// Purely combinational condition evaluator: tests a 4-bit Cond field
// against a stored {N,Z,C,V} value.
module cond_eval
   import cond_pkg::*;
(
   input  logic [3:0] Cond,
   input  logic [3:0] Flags,
   output logic       CondEx
);

   logic n, z, c, v;

   assign n = Flags[FLAG_N];
   assign z = Flags[FLAG_Z];
   assign c = Flags[FLAG_C];
   assign v = Flags[FLAG_V];

   always_comb begin
      CondEx = 1'b0;
      case (Cond)
         COND_EQ: CondEx = z;
         COND_NE: CondEx = ~z;
         COND_CS: CondEx = c;
         COND_CC: CondEx = ~c;
         COND_MI: CondEx = n;
         COND_PL: CondEx = ~n;
         COND_VS: CondEx = v;
         COND_VC: CondEx = ~v;
         COND_HI: CondEx = c & ~z;
         COND_LS: CondEx = ~c | z;
         COND_GE: CondEx = (n == v);
         COND_LT: CondEx = (n != v);
         COND_GT: CondEx = ~z & (n == v);
         COND_LE: CondEx = z | (n != v);
         COND_AL: CondEx = 1'b1;
         default: CondEx = 1'b0;
      endcase
   end

endmodule

// File: rtl/cond_flag_unit.sv
// Condition/flag stage after the ALU: NZCV register, condition gating of
// PCSrc/RegWrite/MemWrite. Optional ExecCnt/SquashCnt under COND_PERF_CNT_EN.
module cond_flag_unit
   import cond_pkg::*;
#(
   parameter logic [3:0] FLAG_RESET = 4'b0000,
   parameter int         CNT_W      = 32
) (
   input  logic             CLK,
   input  logic             RESET_n,
   input  logic             Valid,
   input  logic             Stall,
   input  logic [3:0]       Cond,
   input  logic             PCS,
   input  logic             RegW,
   input  logic             MemW,
   input  logic             NoWrite,
   input  logic [1:0]       FlagW,
   input  logic [3:0]       ALUFlags,
   output logic             CondEx,
   output logic             PCSrc,
   output logic             RegWrite,
   output logic             MemWrite,
   output logic             C_Flag,
`ifdef COND_PERF_CNT_EN
   output logic [CNT_W-1:0] ExecCnt,
   output logic [CNT_W-1:0] SquashCnt,
`endif
   output logic [3:0]       Flags
);

   logic [3:0] nzcv_p1;
   logic       issue_p0;
   logic       go_p0;

   if (CNT_W < 1) begin : g_bad_cnt_w
      $error("cond_flag_unit: CNT_W must be at least 1");
   end

   // Stage p0: evaluate on the stored flags only, so C_Flag never loops through the ALU
   cond_eval u_cond_eval (
      .Cond   (Cond),
      .Flags  (nzcv_p1),
      .CondEx (CondEx)
   );

   assign issue_p0 = Valid & ~Stall;
   assign go_p0    = issue_p0 & CondEx;

   assign PCSrc    = PCS & go_p0;
   assign RegWrite = RegW & ~NoWrite & go_p0;
   assign MemWrite = MemW & go_p0;

   // Stage p1: architectural NZCV, halves written independently
   always_ff @(posedge CLK or negedge RESET_n) begin
      if (!RESET_n) begin
         nzcv_p1 <= FLAG_RESET;
      end else if (go_p0) begin
         if (FlagW[FLAGW_NZ]) begin
            nzcv_p1[FLAG_N] <= ALUFlags[FLAG_N];
            nzcv_p1[FLAG_Z] <= ALUFlags[FLAG_Z];
         end
         if (FlagW[FLAGW_CV]) begin
            nzcv_p1[FLAG_C] <= ALUFlags[FLAG_C];
            nzcv_p1[FLAG_V] <= ALUFlags[FLAG_V];
         end
      end
   end

   assign Flags  = nzcv_p1;
   assign C_Flag = nzcv_p1[FLAG_C];

`ifdef COND_PERF_CNT_EN
   always_ff @(posedge CLK or negedge RESET_n) begin
      if (!RESET_n) begin
         ExecCnt   <= '0;
         SquashCnt <= '0;
      end else if (issue_p0) begin
         if (CondEx) ExecCnt   <= ExecCnt + 1'b1;
         else        SquashCnt <= SquashCnt + 1'b1;
      end
   end
`endif

endmodule
